// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with framing/parity checks, receive FIFO and CPU read port
module ps2_rx_fifo #(
   parameter int DEPTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KB_CLK,
   input  logic       KB_DATA,
   input  logic       CS,
   input  logic       REG,
   output logic [7:0] DOUT,
   output logic       IRQ
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   s_clk, s_data;
   logic                   fclk, flip, fall;
   logic [FW-1:0]          flt_cnt;

   state_t                 state, nxt;
   logic [7:0]             shift;
   logic [2:0]             bit_cnt;
   logic                   par_bit;
   logic [TW-1:0]          timer;
   logic                   timeout;
   logic                   push_req, ferr_set, perr_set;

   logic [7:0]             mem [DEPTH];
   logic [AW-1:0]          rd_ptr, wr_ptr;
   logic [AW:0]            count;
   logic                   full, not_empty;
   logic                   data_rd, stat_rd, pop, push, ovf_set;
   logic                   ovf, ferr, perr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], KB_CLK};
         data_sync <= {data_sync[SYNC_STAGES-2:0], KB_DATA};
      end
   end

   assign s_clk  = clk_sync[SYNC_STAGES-1];
   assign s_data = data_sync[SYNC_STAGES-1];

   // fclk follows s_clk only after FILTER_LEN consecutive differing samples
   assign flip = (s_clk != fclk) && (flt_cnt == FW'(FILTER_LEN - 1));
   assign fall = flip && fclk;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fclk    <= 1'b1;
         flt_cnt <= '0;
      end else if (s_clk == fclk) begin
         flt_cnt <= '0;
      end else if (flip) begin
         fclk    <= s_clk;
         flt_cnt <= '0;
      end else begin
         flt_cnt <= flt_cnt + FW'(1);
      end
   end

   assign timeout = (state != S_IDLE) && (timer == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (timeout) begin
         nxt = S_IDLE;
      end else if (fall) begin
         case (state)
            S_IDLE:   if (!s_data) nxt = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) nxt = S_PARITY;
            S_PARITY: nxt = S_STOP;
            default:  nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      push_req = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
      if (timeout) begin
         ferr_set = 1'b1;
      end else if (fall) begin
         case (state)
            S_IDLE: ferr_set = s_data;
            S_STOP: begin
               if (!s_data)                  ferr_set = 1'b1;
               else if (!(^{shift, par_bit})) perr_set = 1'b1;
               else                           push_req = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
         timer   <= '0;
      end else begin
         if (state == S_IDLE || fall) timer <= '0;
         else if (!timeout)           timer <= timer + TW'(1);
         if (fall) begin
            case (state)
               S_IDLE: begin
                  bit_cnt <= '0;
                  shift   <= '0;
               end
               S_DATA: begin
                  shift[bit_cnt] <= s_data;
                  bit_cnt        <= bit_cnt + 3'd1;
               end
               S_PARITY: par_bit <= s_data;
               default: ;
            endcase
         end
      end
   end

   assign full      = (count == (AW+1)'(DEPTH));
   assign not_empty = (count != '0);
   assign data_rd   = CS && !REG;
   assign stat_rd   = CS && REG;
   assign pop       = data_rd && not_empty;
   // a same-cycle pop frees the slot, so a full FIFO still accepts the byte
   assign push      = push_req && (!full || pop);
   assign ovf_set   = push_req && full && !pop;

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DOUT <= 8'h00;
         IRQ  <= 1'b0;
         ovf  <= 1'b0;
         ferr <= 1'b0;
         perr <= 1'b0;
      end else begin
         if (data_rd)      DOUT <= not_empty ? mem[rd_ptr] : 8'h00;
         else if (stat_rd) DOUT <= {3'b000, ovf, ferr, perr, full, not_empty};
         IRQ  <= not_empty;
         ovf  <= (ovf  && !stat_rd) || ovf_set;
         ferr <= (ferr && !stat_rd) || ferr_set;
         perr <= (perr && !stat_rd) || perr_set;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 20000;
   localparam int HALF    = 10;

   logic       CLK = 1'b0;
   logic       RST, KB_CLK, KB_DATA, CS, REG;
   logic [7:0] DOUT;
   logic       IRQ;

   always #5 CLK = ~CLK;

   ps2_rx_fifo #(
      .DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .CLK(CLK), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA),
      .CS(CS), .REG(REG), .DOUT(DOUT), .IRQ(IRQ)
   );

   typedef struct {
      logic [7:0] d;
      logic       bad_par;
      logic       bad_stop;
      logic [7:0] exp_status;
   } vec_t;

   vec_t       vecs[6];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   logic       m_ovf, m_ferr, m_perr;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic model_push(input logic [7:0] d);
      if (sb.size() < DEPTH) sb.push_back(d);
      else                   m_ovf = 1'b1;
   endtask

   task automatic read_data(input string name);
      logic [7:0] exp;
      @(negedge CLK);
      CS = 1'b1; REG = 1'b0;
      @(negedge CLK);
      CS = 1'b0;
      exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
      check(name, DOUT, exp);
   endtask

   task automatic read_status(input string name, input logic [7:0] exp);
      @(negedge CLK);
      CS = 1'b1; REG = 1'b1;
      @(negedge CLK);
      CS = 1'b0; REG = 1'b0;
      check(name, DOUT, exp);
      m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
   endtask

   task automatic drive_bit(input logic b);
      @(negedge CLK);
      KB_DATA = b;
      repeat (HALF) @(negedge CLK);
      KB_CLK = 1'b0;
      repeat (HALF) @(negedge CLK);
      KB_CLK = 1'b1;
   endtask

   // mode 0: plain; 1: data read lands on the stop-bit fall; 2: check IRQ rise timing
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                             input int mode);
      logic [10:0] bits;
      logic [7:0]  exp;
      bits = {~bad_stop, bad_par ? ^d : ~^d, d, 1'b0};
      for (int i = 0; i < 10; i++) drive_bit(bits[i]);
      @(negedge CLK);
      KB_DATA = bits[10];
      repeat (HALF) @(negedge CLK);
      KB_CLK = 1'b0;
      if (mode == 1) begin
         repeat (5) @(negedge CLK);
         CS = 1'b1; REG = 1'b0;
         @(negedge CLK);
         CS = 1'b0;
         exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
         check("coincide_read", DOUT, exp);
         repeat (HALF - 6) @(negedge CLK);
      end else if (mode == 2) begin
         repeat (6) @(negedge CLK);
         check("irq_before", {7'd0, IRQ}, 8'h00);
         @(negedge CLK);
         check("irq_rise", {7'd0, IRQ}, 8'h01);
         repeat (HALF - 7) @(negedge CLK);
      end else begin
         repeat (HALF) @(negedge CLK);
      end
      KB_CLK = 1'b1;
      KB_DATA = 1'b1;
      repeat (HALF) @(negedge CLK);
      if (bad_stop)     m_ferr = 1'b1;
      else if (bad_par) m_perr = 1'b1;
      else              model_push(d);
   endtask

   initial begin
      vecs[0] = '{8'h1C, 1'b0, 1'b0, 8'h01};
      vecs[1] = '{8'h5A, 1'b1, 1'b0, 8'h04};
      vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h01};
      vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'h01};
      vecs[4] = '{8'h81, 1'b0, 1'b1, 8'h08};
      vecs[5] = '{8'hE7, 1'b1, 1'b0, 8'h04};

      m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      RST = 1'b1; KB_CLK = 1'b1; KB_DATA = 1'b1; CS = 1'b0; REG = 1'b0;
      repeat (5) @(negedge CLK);
      check("reset_dout", DOUT, 8'h00);
      check("reset_irq", {7'd0, IRQ}, 8'h00);
      RST = 1'b0;
      repeat (10) @(negedge CLK);
      read_status("reset_status", 8'h00);

      send_frame(8'h1C, 1'b0, 1'b0, 2);
      read_status("single_status", 8'h01);
      read_data("single_data");
      read_status("single_status2", 8'h00);
      check("single_irq_low", {7'd0, IRQ}, 8'h00);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, 0);
         check($sformatf("vec%0d_irq", i), {7'd0, IRQ}, {7'd0, vecs[i].exp_status[0]});
         read_status($sformatf("vec%0d_status", i), vecs[i].exp_status);
         read_data($sformatf("vec%0d_data", i));
         read_status($sformatf("vec%0d_status2", i), 8'h00);
         check($sformatf("vec%0d_irq_low", i), {7'd0, IRQ}, 8'h00);
      end

      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
      read_status("ovf_status", 8'h13);
      for (int i = 0; i < 9; i++) read_data($sformatf("ovf_drain%0d", i));

      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      repeat (TIMEOUT + 10) @(negedge CLK);
      read_status("timeout_status", 8'h08);
      send_frame(8'hF0, 1'b0, 1'b0, 0);
      read_data("timeout_next_data");
      read_status("timeout_next_status", 8'h00);

      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 0);
      send_frame(8'h18, 1'b0, 1'b0, 1);
      read_status("coincide_status", 8'h03);
      for (int i = 0; i < 9; i++) read_data($sformatf("coincide_drain%0d", i));

      send_frame(8'h33, 1'b0, 1'b0, 0);
      read_status("pre_reset_status", 8'h01);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      @(negedge CLK);
      KB_DATA = 1'b0;
      repeat (HALF) @(negedge CLK);
      KB_CLK = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      KB_CLK = 1'b1; KB_DATA = 1'b1;
      repeat (10) @(negedge CLK);
      check("midreset_dout", DOUT, 8'h00);
      check("midreset_irq", {7'd0, IRQ}, 8'h00);
      RST = 1'b0;
      sb.delete();
      m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      repeat (20) @(negedge CLK);
      read_status("post_reset_status", 8'h00);
      send_frame(8'hAA, 1'b0, 1'b0, 0);
      check("post_reset_irq", {7'd0, IRQ}, 8'h01);
      read_data("post_reset_data");
      read_status("post_reset_status2", 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
